ecg_playback_ctrl: RTL and testbench

Playback controller for the ECG sample ROM. It paces the ROM's `start` enable at a programmable sample rate, restarts the ROM through its synchronous reset, and buffers each sample into a one-entry valid/ready output register for the filter chain. It supports single-shot or looped playback, stop/abort, backpressure stalls, and sticky overrun/error reporting.

---
 rtl/ecg_playback_ctrl.sv | 170 +++++++++++++++++
 tb/tb_ecg_playback_ctrl.sv | 253 +++++++++++++++++++++++++
 2 files changed

// File: rtl/ecg_playback_ctrl.sv
// Playback controller for the ECG sample ROM: paces ROM fetches, restarts the
// ROM through its reset, and buffers each sample in a one-entry valid/ready register.
module ecg_playback_ctrl #(
    parameter int NBIT     = 16,
    parameter int NSAMPLES = 2048,
    parameter int CLK_DIV  = 8,
    parameter int IDXW     = $clog2(NSAMPLES)
) (
    input  logic            clk,
    input  logic            rst,
    input  logic            cmd_start,
    input  logic            cmd_stop,
    input  logic            loop_en,
    output logic            src_rst,
    output logic            src_start,
    input  logic [NBIT-1:0] src_sample,
    input  logic            src_over,
    output logic [NBIT-1:0] out_sample,
    output logic [IDXW-1:0] out_idx,
    output logic            out_valid,
    input  logic            out_ready,
    output logic            busy,
    output logic            done,
    output logic            overrun,
    output logic            err
);

    typedef enum logic [2:0] {
        S_IDLE,
        S_INIT,
        S_FETCH,
        S_CAPTURE,
        S_WAIT,
        S_DONE
    } state_t;

    localparam int DIVW = $clog2(CLK_DIV);
    localparam logic [DIVW-1:0] DIV_LAST = DIVW'(CLK_DIV - 1);
    localparam logic [DIVW-1:0] DIV_ONE  = DIVW'(1);
    localparam logic [IDXW:0]   FCNT_END = (IDXW + 1)'(NSAMPLES);
    localparam logic [IDXW:0]   FCNT_ONE = (IDXW + 1)'(1);

    state_t            state_reg, state_next;
    logic [IDXW:0]     fcnt_reg, fcnt_next;
    logic [DIVW-1:0]   div_reg, div_next;
    logic [DIVW-1:0]   div_inc;
    logic [NBIT-1:0]   out_sample_reg, out_sample_next;
    logic [IDXW-1:0]   out_idx_reg, out_idx_next;
    logic              out_valid_reg, out_valid_next;
    logic              overrun_reg, overrun_next;
    logic              err_reg, err_next;

    // Divider counts cycles since the last FETCH (0 in FETCH) and saturates.
    assign div_inc = (div_reg == DIV_LAST) ? div_reg : div_reg + DIV_ONE;

    always_ff @(posedge clk) begin
        if (rst) begin
            state_reg      <= S_IDLE;
            fcnt_reg       <= '0;
            div_reg        <= '0;
            out_sample_reg <= '0;
            out_idx_reg    <= '0;
            out_valid_reg  <= 1'b0;
            overrun_reg    <= 1'b0;
            err_reg        <= 1'b0;
        end else begin
            state_reg      <= state_next;
            fcnt_reg       <= fcnt_next;
            div_reg        <= div_next;
            out_sample_reg <= out_sample_next;
            out_idx_reg    <= out_idx_next;
            out_valid_reg  <= out_valid_next;
            overrun_reg    <= overrun_next;
            err_reg        <= err_next;
        end
    end

    always_comb begin
        state_next      = state_reg;
        fcnt_next       = fcnt_reg;
        div_next        = div_reg;
        out_sample_next = out_sample_reg;
        out_idx_next    = out_idx_reg;
        out_valid_next  = out_valid_reg;
        overrun_next    = overrun_reg;
        err_next        = err_reg;

        // A transfer empties the buffer unless CAPTURE reloads it below.
        if (out_valid_reg && out_ready) begin
            out_valid_next = 1'b0;
        end

        case (state_reg)
            S_IDLE: begin
                if (cmd_start) begin
                    state_next = S_INIT;
                end
            end
            S_DONE: begin
                if (cmd_start) begin
                    state_next   = S_INIT;
                    err_next     = 1'b0;
                    overrun_next = 1'b0;
                end
            end
            S_INIT: begin
                fcnt_next  = '0;
                div_next   = '0;
                state_next = S_FETCH;
            end
            S_FETCH: begin
                div_next   = div_inc;
                state_next = S_CAPTURE;
            end
            S_CAPTURE: begin
                if (src_over) begin
                    err_next   = 1'b1;
                    state_next = S_DONE;
                end else if (out_valid_reg && !out_ready) begin
                    // Stall: the ROM keeps its sample, and the divider pauses so
                    // the next FETCH slips by exactly the stall length.
                    overrun_next = 1'b1;
                end else begin
                    out_sample_next = src_sample;
                    out_idx_next    = fcnt_reg[IDXW-1:0];
                    out_valid_next  = 1'b1;
                    fcnt_next       = fcnt_reg + FCNT_ONE;
                    div_next        = div_inc;
                    state_next      = S_WAIT;
                end
            end
            S_WAIT: begin
                div_next = div_inc;
                if (div_reg == DIV_LAST) begin
                    if (fcnt_reg < FCNT_END) begin
                        div_next   = '0;
                        state_next = S_FETCH;
                    end else if (loop_en) begin
                        state_next = S_INIT;
                    end else begin
                        state_next = S_DONE;
                    end
                end
            end
            default: begin
                state_next = S_IDLE;
            end
        endcase

        // Stop overrides every transition; sticky flags keep their current value.
        if (cmd_stop && state_reg != S_IDLE) begin
            state_next     = S_IDLE;
            out_valid_next = 1'b0;
            err_next       = err_reg;
            overrun_next   = overrun_reg;
        end
    end

    assign src_rst    = (state_reg == S_INIT);
    assign src_start  = (state_reg == S_FETCH);
    assign busy       = (state_reg == S_INIT) || (state_reg == S_FETCH) ||
                        (state_reg == S_CAPTURE) || (state_reg == S_WAIT);
    assign done       = (state_reg == S_DONE);
    assign out_sample = out_sample_reg;
    assign out_idx    = out_idx_reg;
    assign out_valid  = out_valid_reg;
    assign overrun    = overrun_reg;
    assign err        = err_reg;

endmodule

// File: tb/tb_ecg_playback_ctrl.sv
// Directed/randomized bench for ecg_playback_ctrl with a behavioural ROM and
// an arithmetic model of the expected sample order and delivery cycles.
module tb_ecg_playback_ctrl;

    localparam int NBIT = 16;
    localparam int NS   = 4;
    localparam int DIV  = 8;
    localparam int IDXW = 2;

    logic            clk = 1'b0;
    logic            rst;
    logic            cmd_start, cmd_stop, loop_en, out_ready;
    logic            src_rst, src_start;
    logic [NBIT-1:0] src_sample = '0;
    logic            src_over = 1'b0;
    logic [NBIT-1:0] out_sample;
    logic [IDXW-1:0] out_idx;
    logic            out_valid, busy, done, overrun, err;

    ecg_playback_ctrl #(.NBIT(NBIT), .NSAMPLES(NS), .CLK_DIV(DIV)) dut (
        .clk(clk), .rst(rst), .cmd_start(cmd_start), .cmd_stop(cmd_stop),
        .loop_en(loop_en), .src_rst(src_rst), .src_start(src_start),
        .src_sample(src_sample), .src_over(src_over), .out_sample(out_sample),
        .out_idx(out_idx), .out_valid(out_valid), .out_ready(out_ready),
        .busy(busy), .done(done), .overrun(overrun), .err(err)
    );

    always #5 clk = ~clk;

    int cyc = 0;
    always @(posedge clk) cyc <= cyc + 1;

    // Behavioural ROM: sync reset, one fetch per enable, over flag past its depth.
    logic [NBIT-1:0] rom_mem [0:NS-1];
    int rom_depth = NS;
    int rom_addr = 0;
    always @(posedge clk) begin
        if (src_rst) begin
            rom_addr <= 0;
            src_over <= 1'b0;
        end else if (src_start) begin
            if (rom_addr >= rom_depth) src_over <= 1'b1;
            else src_sample <= rom_mem[rom_addr];
            rom_addr <= rom_addr + 1;
        end
    end

    // Transfer log plus ROM-reset pulse count.
    logic [NBIT-1:0] q_samp[$];
    int              q_idx[$];
    int              q_cyc[$];
    int              rst_cnt = 0;
    always @(negedge clk) begin
        if (out_valid === 1'b1 && out_ready === 1'b1) begin
            q_samp.push_back(out_sample);
            q_idx.push_back(int'(out_idx));
            q_cyc.push_back(cyc);
            $display("xfer cyc=%0d idx=%0d sample=%04h", cyc, out_idx, out_sample);
        end
        if (src_rst === 1'b1) rst_cnt++;
    end

    int total = 0;
    int bad = 0;
    int s = 0;

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        total++;
        assert (obs === exp)
        else begin
            bad++;
            $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
        end
    endtask

    task automatic tick(input int n);
        repeat (n) begin
            @(posedge clk);
            #1;
        end
    endtask

    task automatic load_rom();
        for (int i = 0; i < NS; i++) rom_mem[i] = NBIT'($urandom);
    endtask

    task automatic clear_q();
        q_samp.delete();
        q_idx.delete();
        q_cyc.delete();
    endtask

    task automatic start_pulse();
        cmd_start = 1'b1;
        s = cyc;
        tick(1);
        cmd_start = 1'b0;
    endtask

    task automatic wait_done(input string tag);
        int n = 0;
        while (done !== 1'b1 && n < 2000) begin
            tick(1);
            n++;
        end
        chk(tag, done, 1'b1);
    endtask

    task automatic wait_xfers(input string tag, input int cnt);
        int n = 0;
        while (q_idx.size() < cnt && n < 2000) begin
            tick(1);
            n++;
        end
        chk(tag, q_idx.size(), cnt);
    endtask

    // Expected record: sample i is record entry i mod NS; with timing, first
    // delivery 4 cycles after start, then DIV apart plus one per loop wrap.
    task automatic check_seq(input string tag, input int cnt, input bit timing);
        chk({tag, "_count"}, q_idx.size(), cnt);
        for (int i = 0; i < q_idx.size() && i < cnt; i++) begin
            chk($sformatf("%s_idx%0d", tag, i), q_idx[i], i % NS);
            chk($sformatf("%s_samp%0d", tag, i), q_samp[i], rom_mem[i % NS]);
            if (timing)
                chk($sformatf("%s_cyc%0d", tag, i), q_cyc[i], s + 4 + DIV * i + i / NS);
        end
    endtask

    initial begin
        rst = 1'b1; cmd_start = 1'b0; cmd_stop = 1'b0; loop_en = 1'b0; out_ready = 1'b1;
        load_rom();
        tick(3);
        chk("rst_src_rst", src_rst, 0);
        chk("rst_src_start", src_start, 0);
        chk("rst_out_sample", out_sample, 0);
        chk("rst_out_idx", out_idx, 0);
        chk("rst_out_valid", out_valid, 0);
        chk("rst_busy", busy, 0);
        chk("rst_done", done, 0);
        chk("rst_overrun", overrun, 0);
        chk("rst_err", err, 0);
        rst = 1'b0;
        tick(2);

        // Single-shot playback with free-running downstream.
        clear_q();
        start_pulse();
        chk("A_src_rst_c1", src_rst, 1);
        chk("A_busy_c1", busy, 1);
        tick(1);
        chk("A_src_start_c2", src_start, 1);
        wait_done("A_done");
        chk("A_done_cyc", cyc, s + 3 + DIV * (NS - 1) + DIV - 1);
        chk("A_busy_end", busy, 0);
        check_seq("A", NS, 1'b1);

        // Looped playback, then stop together with start during WAIT after idx 1.
        load_rom();
        loop_en = 1'b1;
        clear_q();
        rst_cnt = 0;
        start_pulse();
        wait_xfers("B_xfers", 2 * NS + 2);
        cmd_stop = 1'b1;
        cmd_start = 1'b1;
        tick(1);
        cmd_stop = 1'b0;
        cmd_start = 1'b0;
        chk("B_stop_busy", busy, 0);
        chk("B_stop_valid", out_valid, 0);
        chk("B_stop_done", done, 0);
        tick(20);
        chk("B_idle_busy", busy, 0);
        chk("B_rom_resets", rst_cnt, 3);
        check_seq("B", 2 * NS + 2, 1'b1);
        loop_en = 1'b0;

        // Backpressure after the first sample; replay starts again at idx 0.
        load_rom();
        clear_q();
        start_pulse();
        wait_xfers("C_first", 1);
        out_ready = 1'b0;
        tick(20 + $urandom_range(0, 5));
        chk("C_overrun", overrun, 1);
        chk("C_hold_valid", out_valid, 1);
        chk("C_hold_idx", out_idx, 1);
        chk("C_hold_samp", out_sample, rom_mem[1]);
        chk("C_no_xfer", q_idx.size(), 1);
        chk("C_busy", busy, 1);
        out_ready = 1'b1;
        wait_done("C_done");
        check_seq("C", NS, 1'b0);
        chk("C_overrun_sticky", overrun, 1);
        chk("C_err", err, 0);

        // ROM shorter than the record: over flag ends playback with err.
        load_rom();
        rom_depth = NS - 1;
        clear_q();
        start_pulse();
        chk("D_overrun_cleared", overrun, 0);
        wait_done("D_done");
        chk("D_err", err, 1);
        chk("D_busy", busy, 0);
        tick(3);
        check_seq("D", NS - 1, 1'b1);

        // Reset mid-record while a sample is held.
        rom_depth = NS;
        load_rom();
        clear_q();
        start_pulse();
        chk("E_err_cleared", err, 0);
        wait_xfers("E_first", 1);
        out_ready = 1'b0;
        tick(12);
        chk("E_valid_before_rst", out_valid, 1);
        rst = 1'b1;
        tick(1);
        chk("E_rst_valid", out_valid, 0);
        chk("E_rst_sample", out_sample, 0);
        chk("E_rst_idx", out_idx, 0);
        chk("E_rst_busy", busy, 0);
        chk("E_rst_done", done, 0);
        chk("E_rst_src", {src_rst, src_start}, 0);
        chk("E_rst_flags", {overrun, err}, 0);
        rst = 1'b0;
        out_ready = 1'b1;
        tick(1);
        clear_q();
        start_pulse();
        wait_done("E_done");
        check_seq("E", NS, 1'b1);

        // Random backpressure: order and content must survive any stall pattern.
        load_rom();
        clear_q();
        start_pulse();
        for (int n = 0; n < 2000 && !(done === 1'b1 && out_valid === 1'b0); n++) begin
            out_ready = 1'($urandom_range(0, 1));
            tick(1);
        end
        out_ready = 1'b1;
        chk("F_done", done, 1);
        check_seq("F", NS, 1'b0);

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule
